ndata_rr_arbiter: RTL and testbench
===================================

Name: ndata_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that merges NUM_INPUTS ndata streams onto one ndata stream.
- It is the counterpart of the stream duplicator: it lets several producers share one downstream consumer, such as a duplicator input, a DMA writer or a shared operator.
- A grant holds from the first beat of a packet until the beat with last=1 has been accepted, so packets never interleave.
- Output goes through a one-stage, full-throughput register slice.

Parameters:
- NUM_INPUTS, 2, number of requesting ndata streams (≥2).
- LOCK_ON_LAST, 1, 1 = hold grant until last beat; 0 = re-arbitrate every beat (beat-level RR).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- in  ndata_i.s  array[NUM_INPUTS]  requester streams (data_t, NUM_ELEMENTS shared with out).
- out  ndata_i.m  1  merged stream.
- grant_idx  output  $clog2(NUM_INPUTS)  index of the currently granted input (valid while busy).
- busy  output  1  high while a packet is locked (LOCKED state).

Behaviour:
- Reset:
  - out.valid=0, out.data/keep/last=0.
  - All in[i].ready=0 during reset.
  - State=IDLE, rr_ptr=0, grant_idx=0, busy=0.
- State machine:
  - IDLE: choose the first i with in[i].valid, searching cyclically from rr_ptr. Set grant_idx=i.
    - If the beat is accepted this cycle with last=1 (or LOCK_ON_LAST=0), stay in IDLE and set rr_ptr=(i+1) mod NUM_INPUTS.
    - If accepted with last=0, go to LOCKED.
    - If no input is valid, hold state.
  - LOCKED: only in[grant_idx] is eligible. When its beat with last=1 is accepted, go to IDLE and set rr_ptr=(grant_idx+1) mod NUM_INPUTS. Other inputs' valid is ignored.
- Ready:
  - slice_ready = !out.valid || out.ready.
  - in[i].ready = slice_ready && (i == selected index) && arbitration allows i. All other readies are 0.
  - in[i].ready never depends on in[j].valid for j≠i except through the IDLE selection.
- Register slice:
  - On acceptance, the selected data/keep/last are captured into the output regs and out.valid is set to 1.
  - If out.ready is high with no new beat accepted, out.valid clears.
  - Latency is 1 cycle. Throughput is 1 beat/cycle with back-to-back packets, including a grant switch.
- Boundaries:
  - Single-beat packet (last on first beat): no LOCKED state entered; rr_ptr advances the same cycle.
  - All inputs valid continuously: grants rotate 0,1,…,N-1,0 per packet.
  - Granted input drops valid mid-packet: stay LOCKED, out.valid falls once drained, no other input is served.
  - out.ready low: slice holds; all in.ready=0 once slice is full. Data is stable while valid && !ready.
  - rr_ptr wrap: N-1 → 0.
  - Reset mid-packet: state returns to IDLE and the slice empties. The partial packet is dropped downstream; producers must also be reset.
- Widths: rr_ptr and grant_idx are $clog2(NUM_INPUTS) bits; the cyclic search uses modulo NUM_INPUTS (non-power-of-2 legal).

Optional Feature:
- Macro: NDATA_RR_ARBITER_STATS_EN.
- With the macro defined:
  - Adds ports stats_clear input 1 and pkt_count output NUM_INPUTS×32.
  - pkt_count[i] increments on each accepted last=1 beat of input i and wraps at 2^32.
  - stats_clear (synchronous) zeroes all counters. It wins over a simultaneous increment.
  - Counters reset to 0.
- Without the macro: no ports and no counters. All other behaviour is identical.

Decomposition:
- Shared stream package holds:
  - arb_state_t enum {IDLE, LOCKED}.
  - STATS_CNT_W=32 constant.
  - The cyclic priority-find function (rr_find_first(req, ptr)), also reused by other arbiters.
- One sub-module is natural: ndata_reg_slice (full-throughput 1-deep pipeline register on ndata_i). It is instantiated once on the output.

Test Plan:
- N=4, all valid, 3-beat packets each, out.ready=1 → output packet order in0,in1,in2,in3,in0; no interleaving; 1 beat/cycle sustained; 1-cycle latency.
- in2 only valid, 1-beat packets, from reset → grant_idx=2 each time, rr_ptr=3 after the first packet; out beats on consecutive cycles.
- in0 mid-packet (beat 2 of 4) deasserts valid for 3 cycles while in1 is valid → busy=1, grant_idx=0, in1.ready=0 throughout; in1 served only after in0's last beat.
- out.ready toggling 1,0,0,1 with all inputs valid → out.data/keep/last held stable while stalled; no beat lost or duplicated (scoreboard per input).
- Reset asserted during LOCKED on in3 → next cycle out.valid=0, busy=0; after release, first grant goes to the lowest valid index from rr_ptr=0.
- With NDATA_RR_ARBITER_STATS_EN: 5 packets on in1, 2 on in3 → pkt_count[1]=5, pkt_count[3]=2; stats_clear in the same cycle as in1's last beat → counter reads 0.

Source files
------------

// File: rtl/ndata_rr_arbiter_pkg.sv
// rtl/ndata_rr_arbiter_pkg.sv - shared ndata stream types, arbiter state enum and cyclic priority find
package ndata_rr_arbiter_pkg;

   localparam int NUM_ELEMENTS = 4;
   localparam int ELEM_W       = 8;
   localparam int STATS_CNT_W  = 32;
   // Widest request vector the cyclic search accepts; callers zero-extend into it.
   localparam int RR_MAX_REQ   = 32;
   localparam int RR_IDX_W     = $clog2(RR_MAX_REQ);

   typedef logic [NUM_ELEMENTS-1:0][ELEM_W-1:0] data_t;
   typedef logic [NUM_ELEMENTS-1:0]             keep_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // First set bit of req[0..n-1], searching upward from ptr and wrapping at n.
   // Returns 0 when nothing is requesting; callers qualify with |req.
   function automatic int rr_find_first(input logic [RR_MAX_REQ-1:0] req,
                                        input int ptr,
                                        input int n);
      int                  idx;
      logic [RR_IDX_W-1:0] bit_sel;
      rr_find_first = 0;
      // Walk from the farthest candidate back to ptr so the nearest hit wins.
      for (int k = RR_MAX_REQ - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) begin
               idx = idx - n;
            end
            bit_sel = idx[RR_IDX_W-1:0];
            if (req[bit_sel]) begin
               rr_find_first = idx;
            end
         end
      end
   endfunction

endpackage

// File: rtl/ndata_i.sv
// rtl/ndata_i.sv - ndata stream interface (valid/ready handshake with data, keep, last)
interface ndata_i;
   import ndata_rr_arbiter_pkg::*;

   logic  valid;
   logic  ready;
   data_t data;
   keep_t keep;
   logic  last;

   modport m (output valid, output data, output keep, output last, input ready);
   modport s (input valid, input data, input keep, input last, output ready);

endinterface

// File: rtl/ndata_reg_slice.sv
// rtl/ndata_reg_slice.sv - one-deep full-throughput output register for an ndata stream
module ndata_reg_slice
   import ndata_rr_arbiter_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  data_t in_data,
   input  keep_t in_keep,
   input  logic  in_last,
   ndata_i.m     out
);

   // The register can take a beat when empty or when its current beat leaves this cycle.
   assign in_ready = !out.valid || out.ready;

   // Load on handshake, otherwise drop valid once the held beat is consumed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out.valid <= 1'b0;
         out.data  <= '0;
         out.keep  <= '0;
         out.last  <= 1'b0;
      end else if (in_valid && in_ready) begin
         out.valid <= 1'b1;
         out.data  <= in_data;
         out.keep  <= in_keep;
         out.last  <= in_last;
      end else if (out.ready) begin
         out.valid <= 1'b0;
      end
   end

endmodule

// File: rtl/ndata_rr_arbiter.sv
// rtl/ndata_rr_arbiter.sv - packet-granular round-robin merge of ndata streams; NDATA_RR_ARBITER_STATS_EN adds per-input packet counters
module ndata_rr_arbiter
   import ndata_rr_arbiter_pkg::*;
#(
   parameter int NUM_INPUTS   = 2,
   parameter int LOCK_ON_LAST = 1
)(
   input  logic                          clk,
   input  logic                          rst_n,
   ndata_i.s                             in [NUM_INPUTS],
   ndata_i.m                             out,
   output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
   output logic                          busy
`ifdef NDATA_RR_ARBITER_STATS_EN
   ,
   input  logic                                  stats_clear,
   output logic [NUM_INPUTS-1:0][STATS_CNT_W-1:0] pkt_count
`endif
);

   localparam int IDX_W = $clog2(NUM_INPUTS);

   logic [NUM_INPUTS-1:0] req_valid;
   logic [NUM_INPUTS-1:0] req_last;
   logic [NUM_INPUTS-1:0] req_ready;
   data_t                 req_data [NUM_INPUTS];
   keep_t                 req_keep [NUM_INPUTS];

   arb_state_t            state, state_nxt;
   logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0]      grant_q, grant_nxt;

   logic [IDX_W-1:0]      idle_pick;
   logic [IDX_W-1:0]      sel_idx;
   logic                  any_valid;
   logic                  sel_valid;
   logic                  sel_last;
   data_t                 sel_data;
   keep_t                 sel_keep;
   logic                  slice_ready;
   logic                  accept;

   // Flatten the interface array so the selection logic can index it dynamically.
   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_req
      assign req_valid[g] = in[g].valid;
      assign req_last[g]  = in[g].last;
      assign req_data[g]  = in[g].data;
      assign req_keep[g]  = in[g].keep;
      assign in[g].ready  = req_ready[g];
   end

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (int'(i) == NUM_INPUTS - 1) begin
         next_idx = '0;
      end else begin
         next_idx = i + 1'b1;
      end
   endfunction

   // Pick the source for this cycle: the locked owner, or the nearest requester from rr_ptr.
   always_comb begin
      idle_pick = IDX_W'(rr_find_first(RR_MAX_REQ'(req_valid), int'(rr_ptr), NUM_INPUTS));
      any_valid = |req_valid;
      if (state == LOCKED) begin
         sel_idx   = grant_q;
         sel_valid = req_valid[grant_q];
      end else begin
         sel_idx   = idle_pick;
         sel_valid = any_valid;
      end
      sel_last  = req_last[sel_idx];
      sel_data  = req_data[sel_idx];
      sel_keep  = req_keep[sel_idx];
      accept    = rst_n && slice_ready && sel_valid;
      // Only the selected input sees ready; in LOCKED the owner keeps it even while it stalls.
      req_ready = '0;
      if (rst_n && slice_ready && ((state == LOCKED) || any_valid)) begin
         req_ready[sel_idx] = 1'b1;
      end
   end

   // Next-state: lock on a non-last first beat, release and advance the pointer on the last beat.
   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      grant_nxt  = grant_q;
      case (state)
         IDLE: begin
            if (any_valid) begin
               grant_nxt = idle_pick;
            end
            if (accept) begin
               if (sel_last || (LOCK_ON_LAST == 0)) begin
                  rr_ptr_nxt = next_idx(idle_pick);
               end else begin
                  state_nxt = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (accept && sel_last) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = next_idx(grant_q);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Arbitration state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
      end else begin
         state   <= state_nxt;
         rr_ptr  <= rr_ptr_nxt;
         grant_q <= grant_nxt;
      end
   end

   assign grant_idx = grant_q;
   assign busy      = (state == LOCKED);

   ndata_reg_slice u_out_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (sel_valid),
      .in_ready (slice_ready),
      .in_data  (sel_data),
      .in_keep  (sel_keep),
      .in_last  (sel_last),
      .out      (out)
   );

`ifdef NDATA_RR_ARBITER_STATS_EN
   // Count completed packets per input; clear takes priority over a same-cycle count.
   always_ff @(posedge clk) begin
      if (!rst_n || stats_clear) begin
         pkt_count <= '0;
      end else if (accept && sel_last) begin
         pkt_count[sel_idx] <= pkt_count[sel_idx] + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ndata_rr_arbiter.sv
// tb/tb_ndata_rr_arbiter.sv - directed self-checking bench for ndata_rr_arbiter
module tb_ndata_rr_arbiter;
   import ndata_rr_arbiter_pkg::*;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] grant_idx;
   logic       busy;
`ifdef NDATA_RR_ARBITER_STATS_EN
   logic                  stats_clear;
   logic [N-1:0][31:0]    pkt_count;
`endif

   ndata_i in_if [N] ();
   ndata_i out_if ();

   logic [N-1:0] tb_valid, tb_last, tb_ready;
   data_t        tb_data [N];
   keep_t        tb_keep [N];
   logic         tb_oready;

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign in_if[g].valid = tb_valid[g];
      assign in_if[g].data  = tb_data[g];
      assign in_if[g].keep  = tb_keep[g];
      assign in_if[g].last  = tb_last[g];
      assign tb_ready[g]    = in_if[g].ready;
   end
   assign out_if.ready = tb_oready;

   ndata_rr_arbiter #(.NUM_INPUTS(N), .LOCK_ON_LAST(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in_if),
      .out       (out_if),
      .grant_idx (grant_idx),
      .busy      (busy)
`ifdef NDATA_RR_ARBITER_STATS_EN
      ,
      .stats_clear (stats_clear),
      .pkt_count   (pkt_count)
`endif
   );

   typedef struct {
      int src;
      int pkt;
      int beat;
      int len;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   int en [N], len [N], left [N], pkt [N], beat [N], hold_at [N], hold_cnt [N];
   bit hold_on [N];

   bit   sb_en, contig_chk, hold_chk, stall_chk, toggle_mode, prev_stall, clr_arm;
   int   first_in_cyc, first_out_cyc, last_out_cyc, hold_seen;
   data_t held_data;
   keep_t held_keep;
   logic  held_last;
   logic [3:0] rdy_pat = 4'b1001;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic data_t mk_data(input int s, input int p, input int b);
      mk_data = {8'(s), 8'(p), 8'(b), 8'hA5};
   endfunction

   function automatic keep_t mk_keep(input logic is_last);
      mk_keep = is_last ? 4'b0111 : 4'b1111;
   endfunction

   task automatic push_pkt(input int s, input int p, input int l);
      for (int b = 0; b < l; b++) exp_q.push_back('{src: s, pkt: p, beat: b, len: l});
   endtask

   task automatic reset_prod();
      for (int i = 0; i < N; i++) begin
         en[i] = 0; len[i] = 1; left[i] = 0; pkt[i] = 0; beat[i] = 0;
         hold_at[i] = -1; hold_cnt[i] = 0; hold_on[i] = 1'b0;
      end
      contig_chk = 0; hold_chk = 0; stall_chk = 0; toggle_mode = 0; prev_stall = 0;
      first_in_cyc = -1; first_out_cyc = -1; last_out_cyc = -1; hold_seen = 0;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         hold_on[i]  = (hold_cnt[i] > 0) && (beat[i] == hold_at[i]);
         tb_valid[i] = (en[i] != 0) && (left[i] > 0) && !hold_on[i];
         tb_last[i]  = (beat[i] == len[i] - 1);
         tb_data[i]  = mk_data(i, pkt[i], beat[i]);
         tb_keep[i]  = mk_keep(tb_last[i]);
      end
      tb_oready = toggle_mode ? rdy_pat[cyc[1:0]] : 1'b1;
   endtask

   task automatic tick();
      logic [N-1:0] fire;
      logic         ofire;
      logic         exp_last;
      exp_t         e;
      @(negedge clk);
      fire  = tb_valid & tb_ready;
      ofire = out_if.valid && tb_oready;
      if (fire != '0 && first_in_cyc < 0) first_in_cyc = cyc;
      if (ofire && sb_en) begin
         if (exp_q.size() == 0) begin
            check_eq("extra_beat", 1, 0);
         end else begin
            e = exp_q.pop_front();
            exp_last = (e.beat == e.len - 1);
            check_eq("beat_data", out_if.data, mk_data(e.src, e.pkt, e.beat));
            check_eq("beat_keep_last", {out_if.keep, out_if.last}, {mk_keep(exp_last), exp_last});
            if (first_out_cyc < 0) first_out_cyc = cyc;
            else if (contig_chk) check_eq("beat_gap", cyc, last_out_cyc + 1);
            last_out_cyc = cyc;
         end
      end
      if (hold_chk && hold_on[0]) begin
         check_eq("hold_busy", busy, 1);
         check_eq("hold_grant", grant_idx, 0);
         check_eq("hold_in1_ready", tb_ready[1], 0);
         if (hold_seen > 0) check_eq("hold_drained", out_if.valid, 0);
         hold_seen++;
      end
      if (stall_chk) begin
         if (prev_stall) begin
            check_eq("stall_data", out_if.data, held_data);
            check_eq("stall_keep_last", {out_if.keep, out_if.last}, {held_keep, held_last});
         end
         if (out_if.valid && !tb_oready) begin
            check_eq("stall_readies", tb_ready, 0);
            held_data  = out_if.data;
            held_keep  = out_if.keep;
            held_last  = out_if.last;
            prev_stall = 1;
         end else begin
            prev_stall = 0;
         end
      end
`ifdef NDATA_RR_ARBITER_STATS_EN
      if (clr_arm && fire[1] && tb_last[1]) begin
         stats_clear = 1'b1;
         clr_arm     = 1'b0;
      end
`endif
      @(posedge clk);
      #1;
      cyc++;
`ifdef NDATA_RR_ARBITER_STATS_EN
      stats_clear = 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
         if (fire[i]) begin
            if (beat[i] == len[i] - 1) begin
               beat[i] = 0; pkt[i]++; left[i]--;
            end else begin
               beat[i]++;
            end
         end
         if (hold_on[i]) hold_cnt[i]--;
      end
      drive_inputs();
   endtask

   task automatic run(input string tag, input int max_cycles);
      for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) tick();
      check_eq(tag, exp_q.size(), 0);
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      sb_en = 1'b0;
      clr_arm = 1'b0;
`ifdef NDATA_RR_ARBITER_STATS_EN
      stats_clear = 1'b0;
`endif
      reset_prod();
      for (int i = 0; i < N; i++) begin en[i] = 1; left[i] = 1; end
      drive_inputs();
      tick();
      tick();
      check_eq("rst_readies", tb_ready, 0);
      check_eq("rst_out_valid", out_if.valid, 0);
      check_eq("rst_out_payload", {out_if.data, out_if.keep, out_if.last}, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_grant", grant_idx, 0);
      check_eq("rst_rr_ptr", dut.rr_ptr, 0);
      reset_prod();
      drive_inputs();
      rst_n = 1'b1;

      // All four valid, 3-beat packets, in0 has two: rotation 0,1,2,3,0 back-to-back.
      sb_en = 1'b1;
      contig_chk = 1;
      for (int i = 0; i < N; i++) begin en[i] = 1; len[i] = 3; left[i] = 1; end
      left[0] = 2;
      push_pkt(0, 0, 3); push_pkt(1, 0, 3); push_pkt(2, 0, 3); push_pkt(3, 0, 3); push_pkt(0, 1, 3);
      drive_inputs();
      run("t1_drain", 40);
      check_eq("t1_latency", first_out_cyc, first_in_cyc + 1);

      // From reset, only in2 with single-beat packets.
      rst_n = 1'b0;
      reset_prod();
      drive_inputs();
      tick();
      rst_n = 1'b1;
      contig_chk = 1;
      en[2] = 1; len[2] = 1; left[2] = 3;
      push_pkt(2, 0, 1); push_pkt(2, 1, 1); push_pkt(2, 2, 1);
      drive_inputs();
      tick();
      check_eq("t2_grant", grant_idx, 2);
      check_eq("t2_rr_ptr", dut.rr_ptr, 3);
      check_eq("t2_busy", busy, 0);
      run("t2_drain", 20);

      // in0 stalls before beat 2 of 4 for three cycles while in1 waits.
      reset_prod();
      hold_chk = 1;
      en[0] = 1; len[0] = 4; left[0] = 1; hold_at[0] = 2; hold_cnt[0] = 3;
      en[1] = 1; len[1] = 2; left[1] = 1;
      push_pkt(0, 0, 4); push_pkt(1, 0, 2);
      drive_inputs();
      run("t3_drain", 40);
      check_eq("t3_hold_cycles", hold_seen, 3);
      check_eq("t3_rr_ptr", dut.rr_ptr, 2);

      // out.ready pattern 1,0,0,1 with all valid; rotation resumes at in2.
      reset_prod();
      toggle_mode = 1;
      stall_chk = 1;
      for (int i = 0; i < N; i++) begin en[i] = 1; len[i] = 2; left[i] = 1; end
      push_pkt(2, 0, 2); push_pkt(3, 0, 2); push_pkt(0, 0, 2); push_pkt(1, 0, 2);
      drive_inputs();
      run("t4_drain", 80);

      // Reset while LOCKED on in3, then restart from rr_ptr=0.
      reset_prod();
      sb_en = 1'b0;
      en[3] = 1; len[3] = 4; left[3] = 1;
      drive_inputs();
      for (int k = 0; k < 10 && !(busy && beat[3] == 2); k++) tick();
      check_eq("t5_locked", busy, 1);
      check_eq("t5_grant", grant_idx, 3);
      rst_n = 1'b0;
      tick();
      check_eq("t5_rst_out_valid", out_if.valid, 0);
      check_eq("t5_rst_busy", busy, 0);
      check_eq("t5_rst_readies", tb_ready, 0);
      reset_prod();
      exp_q.delete();
      rst_n = 1'b1;
      sb_en = 1'b1;
      en[1] = 1; len[1] = 2; left[1] = 1;
      en[3] = 1; len[3] = 2; left[3] = 1;
      push_pkt(1, 0, 2); push_pkt(3, 0, 2);
      drive_inputs();
      tick();
      check_eq("t5_first_grant", grant_idx, 1);
      run("t5_drain", 20);

`ifdef NDATA_RR_ARBITER_STATS_EN
      // Five packets on in1 and two on in3, then a clear colliding with a last beat.
      rst_n = 1'b0;
      reset_prod();
      drive_inputs();
      tick();
      rst_n = 1'b1;
      en[1] = 1; len[1] = 2; left[1] = 5;
      en[3] = 1; len[3] = 1; left[3] = 2;
      push_pkt(1, 0, 2); push_pkt(3, 0, 1); push_pkt(1, 1, 2); push_pkt(3, 1, 1);
      push_pkt(1, 2, 2); push_pkt(1, 3, 2); push_pkt(1, 4, 2);
      drive_inputs();
      run("t6_drain", 40);
      check_eq("t6_count1", pkt_count[1], 5);
      check_eq("t6_count3", pkt_count[3], 2);
      check_eq("t6_count0", pkt_count[0], 0);
      reset_prod();
      en[1] = 1; len[1] = 2; left[1] = 1;
      clr_arm = 1'b1;
      push_pkt(1, 0, 2);
      drive_inputs();
      run("t6_clr_drain", 20);
      check_eq("t6_clr_fired", clr_arm, 0);
      check_eq("t6_clr_count1", pkt_count[1], 0);
      check_eq("t6_clr_count3", pkt_count[3], 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
